// File: rtl/cache_set_tag_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cache_set_tag_ctrl
// Purpose  : Tag match, victim selection and refill control for one cache set.
// Revision : 1.0
// ============================================================================
module cache_set_tag_ctrl #(
  parameter int NUM_WAYS = 4,
  parameter int TAG_W    = 20,
  localparam int WAY_W   = $clog2(NUM_WAYS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [TAG_W-1:0] req_tag,
  input  logic             flush,
  output logic             resp_valid,
  output logic             resp_hit,
  output logic [WAY_W-1:0] resp_way,
  output logic             refill_req_valid,
  input  logic             refill_req_ready,
  output logic [TAG_W-1:0] refill_req_tag,
  output logic [WAY_W-1:0] refill_req_way,
  input  logic             refill_done,
  input  logic [WAY_W-1:0] lru_way,
  output logic             access_valid,
  output logic [WAY_W-1:0] access_way
);

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_COMPARE     = 3'd1,
    ST_REFILL_REQ  = 3'd2,
    ST_REFILL_WAIT = 3'd3,
    ST_RESP        = 3'd4
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [NUM_WAYS-1:0]  r_valid;
  logic [TAG_W-1:0]     r_tag [NUM_WAYS];
  logic [TAG_W-1:0]     r_req_tag;
  logic [WAY_W-1:0]     r_way;
  logic                 r_hit;

  logic                 w_hit;
  logic [WAY_W-1:0]     w_hit_way;
  logic                 w_has_free;
  logic [WAY_W-1:0]     w_free_way;
  logic                 w_install;

  // Tags are unique among valid ways, so at most one way can match.
  always_comb begin
    w_hit      = 1'b0;
    w_hit_way  = '0;
    w_has_free = 1'b0;
    w_free_way = '0;
    for (int i = 0; i < NUM_WAYS; i++) begin
      if (r_valid[i] && (r_tag[i] == r_req_tag)) begin
        w_hit     = 1'b1;
        w_hit_way = WAY_W'(i);
      end
    end
    for (int i = NUM_WAYS - 1; i >= 0; i--) begin
      if (!r_valid[i]) begin
        w_has_free = 1'b1;
        w_free_way = WAY_W'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:        if (!flush && req_valid) w_next = ST_COMPARE;
      ST_COMPARE:     w_next = w_hit ? ST_RESP : ST_REFILL_REQ;
      ST_REFILL_REQ:  if (refill_req_ready) w_next = ST_REFILL_WAIT;
      ST_REFILL_WAIT: if (refill_done) w_next = ST_RESP;
      ST_RESP:        w_next = ST_IDLE;
      default:        w_next = ST_IDLE;
    endcase
  end

  assign w_install = (r_state == ST_REFILL_WAIT) && refill_done;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid   <= '0;
      r_req_tag <= '0;
      r_way     <= '0;
      r_hit     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (flush)          r_valid   <= '0;
          else if (req_valid) r_req_tag <= req_tag;
        end
        ST_COMPARE: begin
          r_hit <= w_hit;
          if (w_hit)           r_way <= w_hit_way;
          else if (w_has_free) r_way <= w_free_way;
          else                 r_way <= lru_way;
        end
        ST_REFILL_WAIT: if (refill_done) r_valid[r_way] <= 1'b1;
        default: ;
      endcase
    end
  end

  // Tag storage carries no reset; validity alone qualifies its contents.
  always_ff @(posedge clk) begin
    if (!reset && w_install) r_tag[r_way] <= r_req_tag;
  end

  assign req_ready        = (r_state == ST_IDLE) && !flush && !reset;
  assign refill_req_valid = (r_state == ST_REFILL_REQ);
  assign refill_req_tag   = r_req_tag;
  assign refill_req_way   = r_way;
  assign resp_valid       = (r_state == ST_RESP);
  assign resp_hit         = (r_state == ST_RESP) && r_hit;
  assign resp_way         = r_way;
  assign access_valid     = (r_state == ST_RESP);
  assign access_way       = r_way;

endmodule
`default_nettype wire
